// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler and double-buffered pixel store for the ws2812c strip driver.
// Two requesters write the back buffer; the driver reads the front buffer, refreshed once per frame.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS       = 8,
    parameter int ADDR_BITS      = 3,
    parameter int SYSTEM_CLOCK   = 48000000,
    parameter int REFRESH_HZ     = 60,
    parameter int RESET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter bit REFRESH_ALWAYS = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [23:0]          a_rgb,
    output logic                 a_gnt,
    input  logic                 b_req,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [23:0]          b_rgb,
    output logic                 b_gnt,
    input  logic [ADDR_BITS-1:0] drv_address,
    input  logic                 drv_new_address,
    output logic [7:0]           drv_red,
    output logic [7:0]           drv_green,
    output logic [7:0]           drv_blue,
    output logic                 drv_reset,
    output logic                 busy,
    output logic [7:0]           frame_count,
    output logic                 timeout_err,
    output logic [1:0]           state_dbg
);

    localparam int FRAME_PERIOD = SYSTEM_CLOCK / REFRESH_HZ;
    localparam int TICK_W       = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int RST_W        = $clog2(RESET_CYCLES + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PIX_W        = $clog2(NUM_LEDS + 1);
    localparam int DEPTH        = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [RST_W-1:0]    rst_cnt, rst_cnt_next;
    logic [TO_W-1:0]     to_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic                pending, pending_next;
    logic                dirty;
    logic                copy, frame_done, timed_out;
    logic                last_b;
    logic                wr_en, valid_write;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [23:0]         wr_rgb;
    logic [DEPTH-1:0]    addr_ok;
    logic [23:0]         back_buf  [DEPTH];
    logic [23:0]         front_buf [DEPTH];
    logic [23:0]         rd_rgb;

    for (genvar g = 0; g < DEPTH; g++) begin : g_addr_ok
        assign addr_ok[g] = (g < NUM_LEDS);
    end

    // Handshake: a requester holds req/addr/rgb until gnt; gnt is a same-cycle
    // combinational pulse and the write commits on that clock edge.
    assign a_gnt = a_req & (~b_req | last_b);
    assign b_gnt = b_req & (~a_req | ~last_b);

    assign wr_en       = a_gnt | b_gnt;
    assign wr_addr     = a_gnt ? a_addr : b_addr;
    assign wr_rgb      = a_gnt ? a_rgb : b_rgb;
    assign valid_write = wr_en & addr_ok[wr_addr];

    assign tick = (tick_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= TICK_W'(FRAME_PERIOD - 1);
            last_b   <= 1'b1;
            dirty    <= 1'b0;
        end else begin
            tick_cnt <= tick ? TICK_W'(FRAME_PERIOD - 1) : tick_cnt - TICK_W'(1);
            if (wr_en) last_b <= b_gnt;
            dirty    <= valid_write | (dirty & ~copy);
        end
    end

    // Storage beyond NUM_LEDS is never written, so out-of-range reads return 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                back_buf[i]  <= '0;
                front_buf[i] <= '0;
            end
        end else begin
            if (copy) begin
                for (int i = 0; i < DEPTH; i++) front_buf[i] <= back_buf[i];
            end
            if (valid_write) back_buf[wr_addr] <= wr_rgb;
        end
    end

    assign rd_rgb    = front_buf[drv_address];
    assign drv_red   = rd_rgb[23:16];
    assign drv_green = rd_rgb[15:8];
    assign drv_blue  = rd_rgb[7:0];

    always_comb begin
        state_next   = state;
        rst_cnt_next = rst_cnt;
        pending_next = pending;
        copy         = 1'b0;
        frame_done   = 1'b0;
        timed_out    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick | pending) begin
                    pending_next = 1'b0;
                    if (dirty | REFRESH_ALWAYS) begin
                        copy         = 1'b1;
                        rst_cnt_next = RST_W'(RESET_CYCLES);
                        state_next   = ST_RESET;
                    end
                end
            end
            ST_RESET: begin
                pending_next = pending | tick;
                rst_cnt_next = rst_cnt - RST_W'(1);
                if (rst_cnt == RST_W'(1)) state_next = ST_SEND;
            end
            ST_SEND: begin
                pending_next = pending | tick;
                if (drv_new_address && pix_cnt == PIX_W'(NUM_LEDS - 1)) begin
                    frame_done = 1'b1;
                    state_next = ST_IDLE;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timed_out  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            pending     <= 1'b0;
            to_cnt      <= '0;
            pix_cnt     <= '0;
            frame_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_next;
            rst_cnt <= rst_cnt_next;
            pending <= pending_next;
            if (state == ST_SEND) begin
                to_cnt  <= to_cnt + TO_W'(1);
                pix_cnt <= pix_cnt + PIX_W'(drv_new_address);
            end else begin
                to_cnt  <= '0;
                pix_cnt <= '0;
            end
            if (frame_done) frame_count <= frame_count + 8'd1;
            if (timed_out) timeout_err <= 1'b1;
        end
    end

    assign drv_reset = (state != ST_SEND);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed and randomized bench for ws2812_frame_ctrl, checked against a frame-level
// reference model (frame age, pulse counts and buffer copies) kept in the bench.
module tb_ws2812_frame_ctrl;

    localparam int NUM_LEDS       = 8;
    localparam int ADDR_BITS      = 4;
    localparam int SYSTEM_CLOCK   = 1000;
    localparam int REFRESH_HZ     = 10;
    localparam int RESET_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int FRAME_PERIOD   = SYSTEM_CLOCK / REFRESH_HZ;
    localparam int DEPTH          = 2 ** ADDR_BITS;

    logic                 clk;
    logic                 reset_n;
    logic                 a_req, b_req, a_gnt, b_gnt;
    logic [ADDR_BITS-1:0] a_addr, b_addr, drv_address;
    logic [23:0]          a_rgb, b_rgb;
    logic                 drv_new_address;
    logic [7:0]           drv_red, drv_green, drv_blue, frame_count;
    logic                 drv_reset, busy, timeout_err;
    logic [1:0]           state_dbg;

    int errors;
    int checks;

    // Reference model state
    logic [23:0] m_back  [DEPTH];
    logic [23:0] m_front [DEPTH];
    logic        m_dirty, m_pending, m_in_frame, m_last_b, m_err;
    int          m_age, m_pulses, cyc;
    logic [7:0]  m_fc;
    logic        exp_a_gnt, exp_b_gnt;

    ws2812_frame_ctrl #(
        .NUM_LEDS(NUM_LEDS), .ADDR_BITS(ADDR_BITS), .SYSTEM_CLOCK(SYSTEM_CLOCK),
        .REFRESH_HZ(REFRESH_HZ), .RESET_CYCLES(RESET_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .REFRESH_ALWAYS(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_rgb(a_rgb), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_rgb(b_rgb), .b_gnt(b_gnt),
        .drv_address(drv_address), .drv_new_address(drv_new_address),
        .drv_red(drv_red), .drv_green(drv_green), .drv_blue(drv_blue),
        .drv_reset(drv_reset), .busy(busy), .frame_count(frame_count),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_back[i]  = '0;
            m_front[i] = '0;
        end
        m_dirty = 0; m_pending = 0; m_in_frame = 0; m_last_b = 1; m_err = 0;
        m_age = 0; m_pulses = 0; cyc = 0; m_fc = 0;
    endtask

    function automatic logic m_sending();
        return m_in_frame && (m_age >= RESET_CYCLES);
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [ADDR_BITS-1:0] addr);
        return (int'(addr) < NUM_LEDS) ? m_front[addr] : 24'h0;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_in_frame) return 2'd0;
        return (m_age < RESET_CYCLES) ? 2'd1 : 2'd2;
    endfunction

    // Advance the model across one clock edge using the inputs present before it.
    task automatic model_edge(input logic ag, input logic bg);
        logic tick_now, start, sending, wr;
        int waddr;
        logic [23:0] wdata;
        tick_now = (cyc % FRAME_PERIOD) == (FRAME_PERIOD - 1);
        sending  = m_sending();
        start    = !m_in_frame && (tick_now || m_pending) && m_dirty;
        wr = 0; waddr = 0; wdata = '0;
        if (ag) begin wr = 1; waddr = int'(a_addr); wdata = a_rgb; end
        else if (bg) begin wr = 1; waddr = int'(b_addr); wdata = b_rgb; end
        if (waddr >= NUM_LEDS) wr = 0;
        if (ag || bg) m_last_b = bg;
        m_pending = m_in_frame ? (m_pending | tick_now) : 1'b0;
        if (start) begin
            for (int i = 0; i < DEPTH; i++) m_front[i] = m_back[i];
            m_in_frame = 1; m_age = 0; m_pulses = 0;
        end else if (m_in_frame) begin
            if (sending && drv_new_address) m_pulses++;
            if (sending && m_pulses == NUM_LEDS) begin
                m_fc++; m_in_frame = 0;
            end else if (sending && (m_age - RESET_CYCLES) == TIMEOUT_CYCLES - 1) begin
                m_err = 1; m_in_frame = 0;
            end else begin
                m_age++;
            end
        end
        m_dirty = wr | (m_dirty & !start);
        if (wr) m_back[waddr] = wdata;
        cyc++;
    endtask

    // Called right after a falling edge with inputs already driven.
    task automatic step();
        logic ea, eb;
        #1;
        if (a_req && b_req) begin
            ea = m_last_b; eb = !m_last_b;
        end else begin
            ea = a_req; eb = b_req;
        end
        exp_a_gnt = ea; exp_b_gnt = eb;
        check("a_gnt", 32'(a_gnt), 32'(ea));
        check("b_gnt", 32'(b_gnt), 32'(eb));
        check("drv_rgb", 32'({drv_red, drv_green, drv_blue}), 32'(exp_rgb(drv_address)));
        @(posedge clk);
        model_edge(ea, eb);
        @(negedge clk);
        check("busy", 32'(busy), 32'(m_in_frame));
        check("drv_reset", 32'(drv_reset), 32'(!m_sending()));
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("state_dbg", 32'(state_dbg), 32'(exp_state()));
    endtask

    task automatic wait_until_sending(output int reset_len);
        reset_len = 0;
        for (int n = 0; n < 4 * FRAME_PERIOD; n++) begin
            if (m_sending()) break;
            step();
            if (busy === 1'b1 && drv_reset === 1'b1) reset_len++;
        end
        if (!m_sending()) begin
            checks++;
            errors++;
            $error("FAIL wait_send: no frame reached SEND within bound, busy=%0b drv_reset=%0b", busy, drv_reset);
        end
    endtask

    task automatic send_pulses(input int n);
        drv_new_address = 1'b1;
        repeat (n) step();
        drv_new_address = 1'b0;
    endtask

    task automatic write_a(input logic [ADDR_BITS-1:0] addr, input logic [23:0] rgb);
        a_req = 1'b1; a_addr = addr; a_rgb = rgb;
        step();
        a_req = 1'b0;
    endtask

    initial begin
        int rlen;
        errors = 0; checks = 0;
        a_req = 0; b_req = 0; a_addr = '0; b_addr = '0; a_rgb = '0; b_rgb = '0;
        drv_address = '0; drv_new_address = 0;
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state, and combinational grants while in reset (A wins the first tie)
        a_req = 1; b_req = 1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drv_reset", 32'(drv_reset), 32'd1);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_rgb", 32'({drv_red, drv_green, drv_blue}), 32'd0);
        check("rst_a_gnt", 32'(a_gnt), 32'd1);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Arbitration: both hold req on the same address for 4 cycles
        a_req = 1; b_req = 1; a_addr = 4'd5; b_addr = 4'd5;
        a_rgb = 24'h111111; b_rgb = 24'h222222;
        for (int k = 0; k < 4; k++) begin
            step();
            check("arb_seq_a", 32'(exp_a_gnt), 32'((k % 2) == 0));
        end
        a_req = 0; b_req = 0;

        // Basic frame
        write_a(4'd2, 24'h060000);
        wait_until_sending(rlen);
        check("reset_len", 32'(rlen), 32'(RESET_CYCLES));
        drv_address = 4'd2;
        #1 check("basic_red", 32'(drv_red), 32'h06);
        drv_address = 4'd5;
        #1 check("arb_last_data", 32'({drv_red, drv_green, drv_blue}), 32'h222222);
        send_pulses(NUM_LEDS);
        check("basic_frame_count", 32'(frame_count), 32'd1);
        check("basic_busy_low", 32'(busy), 32'd0);

        // No tearing: a write during SEND is held back until the next frame
        write_a(4'd0, 24'h0000AA);
        wait_until_sending(rlen);
        drv_address = 4'd0;
        write_a(4'd0, 24'h0000FF);
        #1 check("tear_old", 32'(drv_blue), 32'hAA);
        send_pulses(NUM_LEDS);
        #1 check("tear_hold", 32'(drv_blue), 32'hAA);
        wait_until_sending(rlen);
        #1 check("tear_new", 32'(drv_blue), 32'hFF);
        send_pulses(NUM_LEDS);
        check("tear_frame_count", 32'(frame_count), 32'd3);

        // Clean buffer: five ticks with no writes start no frame
        repeat (5 * FRAME_PERIOD + 20) step();
        check("clean_frame_count", 32'(frame_count), 32'd3);
        check("clean_drv_reset", 32'(drv_reset), 32'd1);

        // Timeout boundary
        write_a(4'd7, 24'h123456);
        wait_until_sending(rlen);
        repeat (TIMEOUT_CYCLES - 1) step();
        check("to_not_yet_err", 32'(timeout_err), 32'd0);
        check("to_not_yet_busy", 32'(busy), 32'd1);
        step();
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        check("to_frame_count", 32'(frame_count), 32'd3);

        // Randomized traffic, including discarded out-of-range writes
        for (int k = 0; k < 1500; k++) begin
            if (!a_req && $urandom_range(0, 3) == 0) begin
                a_req = 1; a_addr = ADDR_BITS'($urandom_range(0, DEPTH - 1)); a_rgb = 24'($urandom);
            end
            if (!b_req && $urandom_range(0, 3) == 0) begin
                b_req = 1; b_addr = ADDR_BITS'($urandom_range(0, DEPTH - 1)); b_rgb = 24'($urandom);
            end
            drv_address = ADDR_BITS'($urandom_range(0, DEPTH - 1));
            if (m_sending()) drv_new_address = 1'($urandom_range(0, 1));
            else drv_new_address = ($urandom_range(0, 7) == 0);
            step();
            if (exp_a_gnt) a_req = 0;
            if (exp_b_gnt) b_req = 0;
        end
        a_req = 0; b_req = 0; drv_new_address = 0;

        // Asynchronous reset in the middle of SEND
        write_a(4'd1, 24'hABCDEF);
        wait_until_sending(rlen);
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_drv_reset", 32'(drv_reset), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drv_address = ADDR_BITS'(i);
            #1 check("post_rst_rgb", 32'({drv_red, drv_green, drv_blue}), 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_ctrl.md
# ws2812_frame_ctrl

Frame scheduler and pixel-store arbiter for the `ws2812c` LED-strip driver. Holds a double-buffered RGB framebuffer that two independent requesters write into, for example the encoder UI and an animation engine, under round-robin arbitration. It serves the driver's address lookups from the front buffer and sequences driver reset/transmit cycles at a fixed refresh rate. A frame is only sent when the back buffer has changed, unless `REFRESH_ALWAYS` is set.

## Interface
- `NUM_LEDS`, 8: pixels per strip; must be at least 2.
- `ADDR_BITS`, 3: width of every address port; 2^`ADDR_BITS` ≥ `NUM_LEDS`.
- `SYSTEM_CLOCK`, 48000000: `clk` frequency in Hz.
- `REFRESH_HZ`, 60: frame-tick rate. `FRAME_PERIOD` = `SYSTEM_CLOCK`/`REFRESH_HZ` cycles.
- `RESET_CYCLES`, 16: cycles `drv_reset` is held high before each frame; must be at least 1.
- `TIMEOUT_CYCLES`, 65536: maximum length of the SEND state.
- `REFRESH_ALWAYS`, 0: when 1, every tick starts a frame even if the buffer is clean.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_req` in 1: requester A write request. Held, together with `a_addr`/`a_rgb`, until granted.
- `a_addr` in `ADDR_BITS`: requester A pixel index.
- `a_rgb` in 24: requester A pixel data as {R,G,B}.
- `a_gnt` out 1: one-cycle pulse; the A write commits this cycle.
- `b_req`, `b_addr`, `b_rgb`, `b_gnt`: requester B, identical to A.
- `drv_address` in `ADDR_BITS`: pixel index requested by the driver.
- `drv_new_address` in 1: driver pulse, once per pixel fetched.
- `drv_red`, `drv_green`, `drv_blue` out 8 each: front-buffer pixel at `drv_address`.
- `drv_reset` out 1: active-high driver reset/restart.
- `busy` out 1: high in the RESET and SEND states.
- `frame_count` out 8: completed frames, wraps modulo 256.
- `timeout_err` out 1: sticky; cleared only by `reset_n`.

## Operation
- **Buffers:** back buffer and front buffer, each `NUM_LEDS` × 24 bits, both cleared to 0 on reset.
- **Arbitration:**
  - At most one write per cycle, always into the back buffer.
  - If only one requester has `req` high, it is granted.
  - If both have `req` high, the requester not granted last is granted. The last-grant pointer resets to B, so A wins the first tie.
  - `gnt` is combinational from `req`, and the write commits on that same edge.
  - A write with `addr` ≥ `NUM_LEDS` is granted and discarded, and does not set `dirty`.
- **dirty:** `dirty_next` = `valid_write` | (`dirty` & ~`copy`). A write in the copy cycle therefore leaves `dirty` set.
- **Tick generator:**
  - Free-running down-counter reloaded with `FRAME_PERIOD`−1; `tick` fires when it reaches 0.
  - A `tick` outside IDLE sets `pending`. Further ticks are not queued, since `pending` is a single bit.
- **FSM states:** IDLE, RESET, SEND.
- **IDLE:**
  - `drv_reset`=1.
  - Start condition: (`tick` | `pending`) & (`dirty` | `REFRESH_ALWAYS`).
  - On start: `copy` is asserted for one cycle (front ← back for all entries), `pending` is cleared, the reset counter is loaded with `RESET_CYCLES`, and the FSM goes to RESET.
  - (`tick` | `pending`) without the start condition clears `pending`.
- **RESET:** `drv_reset`=1. The counter decrements each cycle; at 0 the FSM goes to SEND.
- **SEND:**
  - `drv_reset`=0. Each `drv_new_address` pulse is counted.
  - The `NUM_LEDS`-th pulse: `frame_count`+1, then IDLE.
  - After `TIMEOUT_CYCLES` in SEND without completing: `timeout_err` set, `frame_count` unchanged, then IDLE.
- **Driver read:** `drv_*` = front[`drv_address`], combinational. An address ≥ `NUM_LEDS` reads 0. The front buffer changes only on `copy`, which never occurs in SEND, so a frame in flight is never torn.

## Timing
- **Reset values:**
  - Registers: FSM=IDLE, `drv_reset`=1, `busy`=0, `frame_count`=0, `timeout_err`=0, `dirty`=0, `pending`=0.
  - Tick counter = `FRAME_PERIOD`−1.
  - Combinational outputs: `a_gnt`/`b_gnt` follow `req`, and `drv_*` read the cleared front buffer (0).
- **Write latency:** a write granted at edge N is visible on the back buffer after N. It reaches `drv_*` only after the next `copy`.
- **Copy:** the copy edge is the IDLE→RESET edge. `busy` rises on that edge.
- **RESET length:** `drv_reset` stays high for exactly `RESET_CYCLES` cycles after the copy edge, then falls on the RESET→SEND edge.
- **End of SEND:** on the edge that samples the final `drv_new_address`, the FSM moves to IDLE, `drv_reset` rises, `busy` falls and `frame_count` increments.
- **Asynchronous reset mid-frame:** `drv_reset` returns to 1 immediately. Both buffers clear and any frame in progress is abandoned.
- **Tick in the same cycle as frame completion:** the FSM is not IDLE during that cycle, so the tick sets `pending`. The next frame starts on the following cycle if `dirty`.

## Test plan
- **Basic frame:** `SYSTEM_CLOCK`=1000, `REFRESH_HZ`=10, `RESET_CYCLES`=4, `NUM_LEDS`=8. A writes addr 2 = 0x060000. At the first tick, `busy`=1 and `drv_reset` is high for 4 cycles. With `drv_address`=2 during SEND, `drv_red`=0x06. After 8 `drv_new_address` pulses, `frame_count`=1 and `busy`=0.
- **Clean buffer:** no writes, `REFRESH_ALWAYS`=0 → no frame over 5 ticks; `frame_count` stays 0 and `drv_reset` stays 1.
- **Arbitration:** A and B both hold `req` for 4 cycles after reset. Grants alternate A, B, A, B. Same-address conflicts: the last grant's data is the value present in the buffer.
- **No tearing:** write addr 0 = 0x0000FF during SEND. `drv_blue` at addr 0 stays at its old value until the next frame, then reads 0xFF.
- **Timeout:** `TIMEOUT_CYCLES`=32, no `drv_new_address` pulses. `timeout_err`=1 after 32 SEND cycles, FSM back in IDLE, `frame_count` unchanged.
- **Reset mid-frame:** assert `reset_n`=0 during SEND → `drv_reset`=1 and `busy`=0 asynchronously; all `drv_*` read 0 after release.
